// File: rtl/key_press_gen.sv
// Synthetic active-low key generator: bouncy press edge, clean hold, optional bouncy release.
// Optional release bounce compiled in with `define KEY_PRESS_GEN_REL_BOUNCE_EN.
module key_press_gen #(
  parameter int BOUNCE_CNT = 4,
  parameter int BOUNCE_CYC = 50_000,
  parameter int HOLD_CYC   = 2_000_000,
  parameter int CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic       busy,
  output logic       done,
  output logic       key_out,
  output logic [7:0] press_cnt
);

  localparam int TOG_RAW  = $clog2(2 * BOUNCE_CNT + 1);
  localparam int TOG_W    = (TOG_RAW < 1) ? 1 : TOG_RAW;
  localparam int TOG_LAST = (BOUNCE_CNT > 0) ? 2 * BOUNCE_CNT - 1 : 0;

  localparam logic [CNT_W-1:0] BOUNCE_END = CNT_W'(BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(HOLD_CYC - 1);
  localparam logic [TOG_W-1:0] TOG_END    = TOG_W'(TOG_LAST);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_B,
    HOLD,
`ifdef KEY_PRESS_GEN_REL_BOUNCE_EN
    REL_B,
`endif
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] seg_q, seg_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic             key_d;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    seg_d   = '0;
    tog_d   = tog_q;
    key_d   = key_out;

    unique case (state_q)
      IDLE: begin
        key_d = 1'b1;
        if (req) begin
          state_d = (BOUNCE_CNT == 0) ? HOLD : PRESS_B;
          key_d   = 1'b0;
        end
      end

      // Segments alternate 0,1,0,1...; the last one (odd index) is high.
      PRESS_B: begin
        if (seg_q == BOUNCE_END) begin
          if (tog_q == TOG_END) begin
            state_d = HOLD;
            key_d   = 1'b0;
          end else begin
            tog_d = tog_q + 1'b1;
            key_d = ~key_out;
          end
        end else begin
          seg_d = seg_q + 1'b1;
        end
      end

      HOLD: begin
        if (seg_q == HOLD_END) begin
`ifdef KEY_PRESS_GEN_REL_BOUNCE_EN
          state_d = (BOUNCE_CNT > 0) ? REL_B : DONE;
`else
          state_d = DONE;
`endif
          key_d = 1'b1;
        end else begin
          seg_d = seg_q + 1'b1;
        end
      end

`ifdef KEY_PRESS_GEN_REL_BOUNCE_EN
      // Mirror of the press edge: 1,0,1,0...; the last segment is low.
      REL_B: begin
        if (seg_q == BOUNCE_END) begin
          if (tog_q == TOG_END) begin
            state_d = DONE;
            key_d   = 1'b1;
          end else begin
            tog_d = tog_q + 1'b1;
            key_d = ~key_out;
          end
        end else begin
          seg_d = seg_q + 1'b1;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
        key_d   = 1'b1;
      end

      default: begin
        state_d = IDLE;
        key_d   = 1'b1;
      end
    endcase

    // Both counters restart from zero on every state entry.
    if (state_d != state_q) begin
      seg_d = '0;
      tog_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      seg_q     <= '0;
      tog_q     <= '0;
      key_out   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      tog_q   <= tog_d;
      key_out <= key_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      if (state_d == DONE) begin
        press_cnt <= press_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_press_gen.sv
// Directed bench for key_press_gen: bouncy press (BOUNCE_CNT=2) and clean (BOUNCE_CNT=0) instances.
module tb_key_press_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       busy_a, done_a, key_a;
  logic       busy_b, done_b, key_b;
  logic [7:0] pc_a, pc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_press_gen #(.BOUNCE_CNT(2), .BOUNCE_CYC(3), .HOLD_CYC(10), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a),
    .busy(busy_a), .done(done_a), .key_out(key_a), .press_cnt(pc_a)
  );

  key_press_gen #(.BOUNCE_CNT(0), .BOUNCE_CYC(3), .HOLD_CYC(5), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b),
    .busy(busy_b), .done(done_b), .key_out(key_b), .press_cnt(pc_b)
  );

  // Vectors read left to right in time order: busy cycles, then one idle cycle.
`ifdef KEY_PRESS_GEN_REL_BOUNCE_EN
  localparam int          LA     = 35;
  localparam logic [35:0] KEY_A  = 36'b000111000111_0000000000_111000111000_1_1;
  localparam logic [35:0] BUSY_A = 36'hFFFF_FFFF_E;
  localparam logic [35:0] DONE_A = 36'h2;
`else
  localparam int          LA     = 23;
  localparam logic [23:0] KEY_A  = 24'b000111000111_0000000000_1_1;
  localparam logic [23:0] BUSY_A = 24'hFF_FFFE;
  localparam logic [23:0] DONE_A = 24'h2;
`endif
  localparam int         LB     = 6;
  localparam logic [6:0] KEY_B  = 7'b00000_1_1;
  localparam logic [6:0] BUSY_B = 7'b1111110;
  localparam logic [6:0] DONE_B = 7'b0000010;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel_b, input logic v);
    if (sel_b) req_b = v;
    else       req_a = v;
  endtask

  // Called just after a negedge: raises req, then records n cycles; req_mask[i] drives req after sample i.
  task automatic run(input bit sel_b, input int n, input logic [127:0] req_mask,
                     output logic [127:0] key_v, output logic [127:0] busy_v,
                     output logic [127:0] done_v);
    key_v  = '0;
    busy_v = '0;
    done_v = '0;
    drive(sel_b, 1'b1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_v  = {key_v[126:0],  sel_b ? key_b  : key_a};
      busy_v = {busy_v[126:0], sel_b ? busy_b : busy_a};
      done_v = {done_v[126:0], sel_b ? done_b : done_a};
      drive(sel_b, req_mask[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] kv, bv, dv;
    logic [127:0] mask;

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {key_a, busy_a, done_a, pc_a, key_b, busy_b, done_b, pc_b},
            {3'b100, 8'd0, 3'b100, 8'd0});
    end

    // Single press on the bouncy instance.
    run(1'b0, LA + 1, '0, kv, bv, dv);
    check("a_key", kv, 128'(KEY_A));
    check("a_busy", bv, 128'(BUSY_A));
    check("a_done", dv, 128'(DONE_A));
    check("a_cnt1", 128'(pc_a), 128'd1);

    // Mid-sequence req pulses, including one during DONE, must be ignored.
    mask = '0;
    mask[3] = 1'b1;
    mask[14] = 1'b1;
    mask[LA-1] = 1'b1;
    run(1'b0, LA + 1, mask, kv, bv, dv);
    check("a_ign_key", kv, 128'(KEY_A));
    check("a_ign_busy", bv, 128'(BUSY_A));
    check("a_cnt2", 128'(pc_a), 128'd2);

    // req held for three back-to-back presses with one idle cycle between.
    do_reset();
    mask = (128'd1 << (3 * (LA + 1) - 1)) - 128'd1;
    run(1'b0, 3 * (LA + 1), mask, kv, bv, dv);
    check("a_held_key", kv, 128'({KEY_A, KEY_A, KEY_A}));
    check("a_held_busy", bv, 128'({BUSY_A, BUSY_A, BUSY_A}));
    check("a_held_done", dv, 128'({DONE_A, DONE_A, DONE_A}));
    check("a_cnt3", 128'(pc_a), 128'd3);

    // Clean edges when BOUNCE_CNT=0.
    run(1'b1, LB + 1, '0, kv, bv, dv);
    check("b_key", kv, 128'(KEY_B));
    check("b_busy", bv, 128'(BUSY_B));
    check("b_done", dv, 128'(DONE_B));
    check("b_cnt1", 128'(pc_b), 128'd1);

    // press_cnt wrap 255 -> 0.
    for (int i = 0; i < 254; i++) run(1'b1, LB + 1, '0, kv, bv, dv);
    check("b_cnt255", 128'(pc_b), 128'd255);
    run(1'b1, LB + 1, '0, kv, bv, dv);
    check("b_cnt_wrap", 128'(pc_b), 128'd0);

    // Asynchronous reset in the middle of HOLD.
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    repeat (15) @(negedge clk);
    check("a_in_hold", {key_a, busy_a}, 2'b01);
    #1 rst = 1'b1;
    #1;
    check("rst_async", {key_a, busy_a, done_a, pc_a}, {3'b100, 8'd0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, LA + 1, '0, kv, bv, dv);
    check("a_post_rst_key", kv, 128'(KEY_A));
    check("a_post_rst_busy", bv, 128'(BUSY_A));
    check("a_post_rst_cnt", 128'(pc_a), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_press_gen.md
Name: key_press_gen

Overview:
- Transmitter-side companion to the key debouncer. On request, drives a synthetic active-low mechanical key line: a bouncy press edge, a clean hold low, then a bouncy release edge.
- Used for on-board self-test and hardware-in-loop stimulus of the key input path that selects classification mode.
- Sits between the test controller (the req/busy/done handshake) and the key pin mux (key_out).

Parameters:
- BOUNCE_CNT, 4: number of glitch pairs on each edge. 0 means a clean edge with no bounce.
- BOUNCE_CYC, 50_000: clk cycles per bounce segment (1 ms at 50 MHz). Must be >= 1.
- HOLD_CYC, 2_000_000: clk cycles key_out is held stably low (40 ms). Must be >= 1.
- CNT_W, 24: width of the internal segment counter. Must satisfy 2^CNT_W > max(BOUNCE_CYC, HOLD_CYC).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- req  input  1  start one press, sampled only in IDLE
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a press sequence completes
- key_out  output  1  synthetic key line, active-low, idle 1
- press_cnt  output  8  number of completed presses, wraps 255 -> 0

Behaviour:
- Reset values (asynchronous on rst=1, including mid-sequence): state=IDLE, key_out=1, busy=0, done=0, press_cnt=0, segment counter=0, toggle counter=0.
- All outputs are registered. State, key_out and busy change on the same clk edge.
- State machine states: IDLE, PRESS_B, HOLD, REL_B, DONE.
- A "segment" lasts exactly BOUNCE_CYC cycles in PRESS_B/REL_B and exactly HOLD_CYC cycles in HOLD. The segment counter counts 0..len-1 and clears at each segment boundary.
- IDLE:
  - key_out=1.
  - req=1 at edge t: at t+1 the state is PRESS_B (or HOLD if BOUNCE_CNT=0), key_out=0, busy=1.
  - req=0: stay in IDLE.
- PRESS_B:
  - 2*BOUNCE_CNT segments driving key_out = 0,1,0,1,...; the last segment is 1.
  - After the last segment, go to HOLD with key_out=0.
- HOLD:
  - key_out=0 for HOLD_CYC cycles.
  - Then go to REL_B with key_out=1, or to DONE if BOUNCE_CNT=0 or the macro is absent.
- REL_B:
  - 2*BOUNCE_CNT segments driving key_out = 1,0,1,0,...; the last segment is 0.
  - Then go to DONE.
- DONE:
  - Lasts exactly one cycle, with key_out=1, busy=1, done=1.
  - press_cnt increments on entry into DONE, wrapping 255 -> 0.
  - Next state is IDLE.
- req while busy=1 is ignored; there is no queueing. req held high continuously restarts a new press on the first IDLE cycle after DONE, so there is exactly one IDLE cycle between sequences.
- Total busy cycles per press = 2*BOUNCE_CNT*BOUNCE_CYC*(1+R) + HOLD_CYC + 1, where R=1 if the release bounce is enabled, else 0.
- Toggle counter width is ceil(log2(2*BOUNCE_CNT+1)). It clears on every state entry.

Optional Feature:
- Macro: KEY_PRESS_GEN_REL_BOUNCE_EN.
- Defined: REL_B is compiled in, and the release edge bounces as described above.
- Undefined: REL_B is absent. HOLD goes directly to DONE, giving a clean release edge; the busy length formula uses R=0.

Test Plan:
- Reset, then idle 20 cycles -> key_out=1, busy=0, done=0, press_cnt=0 throughout.
- BOUNCE_CNT=2, BOUNCE_CYC=3, HOLD_CYC=10, macro defined, 1-cycle req -> key_out from t+1 reads 000111000111, then 0x10, then 111000111000, then 1. busy high for exactly 35 cycles, done high on cycle 35 only, press_cnt=1.
- Same parameters, macro undefined -> key_out reads 000111000111, 0x10, then 1. busy high for 23 cycles, done high on the last busy cycle.
- BOUNCE_CNT=0, HOLD_CYC=5, req pulse -> key_out low for exactly 5 cycles. busy high for 6 cycles, with no glitches on key_out.
- req pulses while busy, plus req held high for 3 sequences -> mid-sequence req pulses are ignored. The held req gives 3 sequences separated by exactly one IDLE cycle, ending with press_cnt=3. Also: preload 255 presses, then one more -> press_cnt=0.
- rst asserted during HOLD -> key_out=1, busy=0, press_cnt=0 asynchronously, before the next clk edge. After rst is released, a new req produces a full, correct sequence.
